quadrature_encoder_bank: RTL and testbench
==========================================

// Module: quadrature_encoder_bank
// PURPOSE
//  N-channel quadrature encoder front end for the motion system. Generalises the per-channel
//  quad_A/B/I inputs into one parametrised bank: sync, glitch filter, 4x decode, position,
//  index capture and periodic velocity per channel. Exposes a word-wide register port for uP access.
// PARAMETERS
//  NOS_CHANNELS   2       number of encoder channels (matches `NOS_PWM_CHANNELS)
//  COUNT_WIDTH    32      position counter width, two's complement
//  VEL_WIDTH      16      signed velocity width (counts per period)
//  FILTER_DEPTH   3       consecutive equal samples needed to accept a new input level (>=1)
//  VEL_PERIOD     500000  clk cycles per velocity sample (10 ms at 50 MHz)
// PORTS
//  clk          in   1                 system clock
//  reset        in   1                 synchronous, active-high
//  quad_A       in   NOS_CHANNELS      encoder A inputs, asynchronous
//  quad_B       in   NOS_CHANNELS      encoder B inputs, asynchronous
//  quad_I       in   NOS_CHANNELS      encoder index inputs, asynchronous
//  reg_addr     in   8                 register address = ch*4 + offset
//  reg_rd       in   1                 read strobe, 1 cycle
//  reg_wr       in   1                 write strobe, 1 cycle
//  reg_wdata    in   32                write data
//  reg_rdata    out  32                read data, valid with reg_ack
//  reg_ack      out  1                 1-cycle access acknowledge
//  index_irq    out  NOS_CHANNELS      1-cycle pulse on index capture when irq_en set
// BEHAVIOUR
//  Reset: one clock (clk); reset synchronous active-high. All positions, index_pos, velocity,
//   last_pos, period counter, ctrl, status = 0; reg_rdata=0, reg_ack=0, index_irq=0.
//  Input path per signal: 2-FF synchroniser -> filter; filtered level changes only after
//   FILTER_DEPTH identical synchronised samples. Input-to-count latency = 2+FILTER_DEPTH+1 clk.
//  Decode (4x): prev/cur filtered (A,B); 00->01->11->10->00 = +1, reverse = -1 (negated if
//   invert_dir). Both bits change in one cycle = illegal: no count, status.error set (sticky).
//  prev (A,B) tracked always, even when disabled -> no spurious step on enable.
//  Position: wraps modulo 2^COUNT_WIDTH both ways; held while enable=0.
//  Index: rising edge of filtered I (enable=1) -> index_pos <= position (pre-update value),
//   status.index_seen <= 1, index_irq pulse if irq_en. If zero_on_index: position <= step
//   (clear and same-cycle step both apply).
//  Velocity: shared period counter 0..VEL_PERIOD-1; at terminal count, per channel
//   velocity <= sat_VEL_WIDTH(position - last_pos) (diff computed mod 2^COUNT_WIDTH, then
//   saturated to signed range), last_pos <= position. Disabled channel yields 0.
//  Register map (offset): 0 position R/W (write loads, wins over same-cycle step/index clear);
//   1 index_pos R; 2 velocity R (sign-extended); 3 ctrl/status: [0] enable, [1] zero_on_index,
//   [2] invert_dir, [3] irq_en (R/W); [8] index_seen, [9] error (R, write-1-to-clear).
//  Handshake: strobe in cycle n -> reg_ack and reg_rdata in n+1; reg_rdata=0 outside ack.
//   Unmapped addr (ch >= NOS_CHANNELS): ack given, read 0, write ignored.
//   reg_rd & reg_wr together: treated as write, rdata 0. Back-to-back strobes each acked.
//  Simultaneous W1C and new set event on a status bit: set wins.
//  Reset mid-operation: all state cleared next edge, in-flight ack dropped.
// STRUCTURE
//  Package types: quad_offset_t enum {QPOS,QIDX,QVEL,QCTRL}; quad_ctrl_t packed struct
//   {irq_en,invert_dir,zero_on_index,enable}; QUAD_REGS_PER_CH=4 constant.
//  Sub-module quad_decoder_channel (sync, filter, decode, position, index, status),
//   one per channel via generate; top holds period counter, velocity regs, register decode.
// TESTING
//  1 Reset: hold reset 3 clk -> all reads 0, reg_ack low until first strobe.
//  2 enable=1, drive 10 forward quadrature cycles -> position=40; 10 reverse -> 0; invert_dir=1 fwd 1 cycle -> -4.
//  3 Pulse of FILTER_DEPTH-1 clk on A -> no count; toggle A,B same clk -> count held, error=1; write 0x200 clears.
//  4 position write 0xFFFFFFFF, one fwd step -> 0; zero_on_index=1, index edge at pos 123 -> index_pos=123, pos=0, irq 1 clk.
//  5 VEL_PERIOD=100, 25 fwd steps per period -> velocity=25; 40000 steps, VEL_WIDTH=16 -> 32767.
//  6 reg_rd to addr 0x0C with NOS_CHANNELS=2 -> ack n+1, rdata 0; rd&wr same clk -> write applied.

Source files
------------

// File: rtl/quadrature_encoder_bank_pkg.sv
// Shared types and helpers for the quadrature encoder bank.
package quadrature_encoder_bank_pkg;

    typedef enum logic [1:0] {QPOS = 2'd0, QIDX = 2'd1, QVEL = 2'd2, QCTRL = 2'd3} quad_offset_t;

    typedef struct packed {
        logic irq_en;
        logic invert_dir;
        logic zero_on_index;
        logic enable;
    } quad_ctrl_t;

    localparam int unsigned QUAD_REGS_PER_CH = 4;

    typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILLEGAL} quad_step_t;

    // prev/cur are {A,B}; forward order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic quad_step_t quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        quad_step_t s;
        if (prev == cur) begin
            s = STEP_NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            s = STEP_ILLEGAL;
        end else begin
            case ({prev, cur})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_FWD;
                default:                             s = STEP_REV;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/quadrature_encoder_bank_if.sv
// Word-wide register access port of the encoder bank.
interface quadrature_encoder_bank_if;
    logic [7:0]  reg_addr;
    logic        reg_rd;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (output reg_addr, reg_rd, reg_wr, reg_wdata, input reg_rdata, reg_ack);
    modport slave  (input reg_addr, reg_rd, reg_wr, reg_wdata, output reg_rdata, reg_ack);
endinterface

// File: rtl/quadrature_encoder_bank_channel.sv
// One encoder channel: synchroniser, glitch filter, 4x decode, position, index capture, status.
module quad_decoder_channel
    import quadrature_encoder_bank_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH  = 32,
    parameter int unsigned FILTER_DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_a,
    input  logic                   i_b,
    input  logic                   i_i,
    input  quad_ctrl_t             i_ctrl,
    input  logic                   i_pos_wr,
    input  logic [COUNT_WIDTH-1:0] i_pos_wdata,
    input  logic                   i_clr_index_seen,
    input  logic                   i_clr_error,
    output logic [COUNT_WIDTH-1:0] o_position,
    output logic [COUNT_WIDTH-1:0] o_index_pos,
    output logic                   o_index_seen,
    output logic                   o_error,
    output logic                   o_irq
);
    localparam int unsigned FCW = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;

    // Bit order {I, A, B} so that [1:0] is the {A,B} pair fed to the decoder.
    logic [2:0]             r_sync1, r_sync2, r_filt, r_prev;
    logic [FCW-1:0]         r_fcnt [3];
    logic [COUNT_WIDTH-1:0] r_pos, r_idx, w_pos_d;
    logic                   r_seen, r_err, r_irq;
    logic                   w_idx_rise, w_up, w_dn;
    quad_step_t             w_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            r_prev  <= '0;
            for (int k = 0; k < 3; k++) r_fcnt[k] <= '0;
        end else begin
            r_sync1 <= {i_i, i_a, i_b};
            r_sync2 <= r_sync1;
            r_prev  <= r_filt;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_filt[k]) begin
                    r_fcnt[k] <= '0;
                end else if (r_fcnt[k] == FCW'(FILTER_DEPTH - 1)) begin
                    r_filt[k] <= r_sync2[k];
                    r_fcnt[k] <= '0;
                end else begin
                    r_fcnt[k] <= r_fcnt[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_step     = quad_decode(r_prev[1:0], r_filt[1:0]);
        w_idx_rise = i_ctrl.enable & r_filt[2] & ~r_prev[2];
        w_up       = i_ctrl.enable & (w_step == (i_ctrl.invert_dir ? STEP_REV : STEP_FWD));
        w_dn       = i_ctrl.enable & (w_step == (i_ctrl.invert_dir ? STEP_FWD : STEP_REV));
        // Index clear and same-cycle step both apply; a register write overrides everything.
        w_pos_d = (w_idx_rise & i_ctrl.zero_on_index) ? '0 : r_pos;
        if (w_up) begin
            w_pos_d = w_pos_d + 1'b1;
        end else if (w_dn) begin
            w_pos_d = w_pos_d - 1'b1;
        end
        if (i_pos_wr) w_pos_d = i_pos_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos  <= '0;
            r_idx  <= '0;
            r_seen <= 1'b0;
            r_err  <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_pos <= w_pos_d;
            if (w_idx_rise) r_idx <= r_pos;
            r_seen <= (r_seen & ~i_clr_index_seen) | w_idx_rise;
            r_err  <= (r_err & ~i_clr_error) | (i_ctrl.enable & (w_step == STEP_ILLEGAL));
            r_irq  <= w_idx_rise & i_ctrl.irq_en;
        end
    end

    assign o_position   = r_pos;
    assign o_index_pos  = r_idx;
    assign o_index_seen = r_seen;
    assign o_error      = r_err;
    assign o_irq        = r_irq;

endmodule

// File: rtl/quadrature_encoder_bank.sv
// N-channel quadrature encoder bank: per-channel decoders, shared velocity timebase, register port.
module quadrature_encoder_bank
    import quadrature_encoder_bank_pkg::*;
#(
    parameter int unsigned NOS_CHANNELS = 2,
    parameter int unsigned COUNT_WIDTH  = 32,
    parameter int unsigned VEL_WIDTH    = 16,
    parameter int unsigned FILTER_DEPTH = 3,
    parameter int unsigned VEL_PERIOD   = 500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NOS_CHANNELS-1:0] quad_A,
    input  logic [NOS_CHANNELS-1:0] quad_B,
    input  logic [NOS_CHANNELS-1:0] quad_I,
    quadrature_encoder_bank_if.slave bus,
    output logic [NOS_CHANNELS-1:0] index_irq
);
    localparam int unsigned OFF_W = $clog2(QUAD_REGS_PER_CH);
    localparam int unsigned CH_W  = 8 - OFF_W;
    localparam int unsigned PCW   = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;
    localparam logic signed [COUNT_WIDTH-1:0] VEL_MAX = COUNT_WIDTH'(2 ** (VEL_WIDTH - 1) - 1);
    localparam logic signed [COUNT_WIDTH-1:0] VEL_MIN = ~VEL_MAX;

    logic [COUNT_WIDTH-1:0]      w_pos [NOS_CHANNELS];
    logic [COUNT_WIDTH-1:0]      w_idx_pos [NOS_CHANNELS];
    logic signed [VEL_WIDTH-1:0] w_vel [NOS_CHANNELS];
    logic [NOS_CHANNELS-1:0]     w_seen, w_err;
    quad_ctrl_t                  r_ctrl [NOS_CHANNELS];
    logic [PCW-1:0]              r_pcnt;
    logic                        w_tick;
    logic [CH_W-1:0]             w_ch;
    quad_offset_t                w_off;
    logic                        w_mapped, w_wr, w_rd;
    logic [31:0]                 w_rdata, r_rdata;
    logic                        r_ack;

    assign w_ch     = bus.reg_addr[7:OFF_W];
    assign w_off    = quad_offset_t'(bus.reg_addr[OFF_W-1:0]);
    assign w_mapped = 32'(w_ch) < NOS_CHANNELS;
    assign w_wr     = bus.reg_wr;
    assign w_rd     = bus.reg_rd & ~bus.reg_wr;
    assign w_tick   = (r_pcnt == PCW'(VEL_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NOS_CHANNELS; c++) begin
            if (reset) begin
                r_ctrl[c] <= '0;
            end else if (w_wr && w_mapped && w_off == QCTRL && w_ch == CH_W'(c)) begin
                r_ctrl[c] <= quad_ctrl_t'(bus.reg_wdata[3:0]);
            end
        end
    end

    for (genvar c = 0; c < NOS_CHANNELS; c++) begin : g_ch
        logic                        w_sel;
        logic [COUNT_WIDTH-1:0]      r_last, w_diff;
        logic signed [VEL_WIDTH-1:0] r_vel;

        assign w_sel = w_wr & w_mapped & (w_ch == CH_W'(c));

        quad_decoder_channel #(
            .COUNT_WIDTH  (COUNT_WIDTH),
            .FILTER_DEPTH (FILTER_DEPTH)
        ) u_chan (
            .clk              (clk),
            .reset            (reset),
            .i_a              (quad_A[c]),
            .i_b              (quad_B[c]),
            .i_i              (quad_I[c]),
            .i_ctrl           (r_ctrl[c]),
            .i_pos_wr         (w_sel & (w_off == QPOS)),
            .i_pos_wdata      (COUNT_WIDTH'(bus.reg_wdata)),
            .i_clr_index_seen (w_sel & (w_off == QCTRL) & bus.reg_wdata[8]),
            .i_clr_error      (w_sel & (w_off == QCTRL) & bus.reg_wdata[9]),
            .o_position       (w_pos[c]),
            .o_index_pos      (w_idx_pos[c]),
            .o_index_seen     (w_seen[c]),
            .o_error          (w_err[c]),
            .o_irq            (index_irq[c])
        );

        // Difference wraps modulo 2^COUNT_WIDTH before saturation.
        assign w_diff = w_pos[c] - r_last;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_last <= '0;
                r_vel  <= '0;
            end else if (w_tick) begin
                r_last <= w_pos[c];
                if (!r_ctrl[c].enable) begin
                    r_vel <= '0;
                end else if ($signed(w_diff) > VEL_MAX) begin
                    r_vel <= VEL_MAX[VEL_WIDTH-1:0];
                end else if ($signed(w_diff) < VEL_MIN) begin
                    r_vel <= VEL_MIN[VEL_WIDTH-1:0];
                end else begin
                    r_vel <= w_diff[VEL_WIDTH-1:0];
                end
            end
        end

        assign w_vel[c] = r_vel;
    end

    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < NOS_CHANNELS; c++) begin
            if (w_rd && w_mapped && w_ch == CH_W'(c)) begin
                unique case (w_off)
                    QPOS:  w_rdata = 32'(w_pos[c]);
                    QIDX:  w_rdata = 32'(w_idx_pos[c]);
                    QVEL:  w_rdata = 32'(w_vel[c]);
                    QCTRL: w_rdata = {22'd0, w_err[c], w_seen[c], 4'd0, r_ctrl[c]};
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= bus.reg_rd | bus.reg_wr;
            r_rdata <= w_rdata;
        end
    end

    assign bus.reg_ack   = r_ack;
    assign bus.reg_rdata = r_rdata;

endmodule

// File: tb/tb_quadrature_encoder_bank.sv
// Scoreboard bench for quadrature_encoder_bank: directed stimulus, queued expectations, monitor.
module tb_quadrature_encoder_bank;
    import quadrature_encoder_bank_pkg::*;

    localparam int unsigned NCH = 2;
    localparam int unsigned VP  = 100;
    localparam int unsigned FD  = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       a0 = 1'b0, b0 = 1'b0, i0 = 1'b0, a1 = 1'b0, b1 = 1'b0;
    logic [1:0] irq;
    logic       run1 = 1'b0;
    logic       strobe_q = 1'b0;
    int         st0 = 0, st1 = 0, phase = 0, irq_cnt = 0, irq_base = 0;
    int         total = 0, bad = 0;

    logic [31:0] sb_exp[$];
    string       sb_name[$];
    logic [31:0] dc_act[$], dc_exp[$];
    string       dc_name[$];
    logic [31:0] m_exp, m_act;
    string       m_name;

    quadrature_encoder_bank_if bus ();

    quadrature_encoder_bank #(
        .NOS_CHANNELS (NCH),
        .COUNT_WIDTH  (32),
        .VEL_WIDTH    (16),
        .FILTER_DEPTH (FD),
        .VEL_PERIOD   (VP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .quad_A    ({a1, a0}),
        .quad_B    ({b1, b0}),
        .quad_I    ({1'b0, i0}),
        .bus       (bus),
        .index_irq (irq)
    );

    always #5 clk = ~clk;

    // Reference timebase: the velocity window restarts at reset and closes every VP clocks.
    always @(posedge clk) phase <= reset ? 0 : ((phase == VP - 1) ? 0 : phase + 1);
    always @(posedge clk) strobe_q <= reset ? 1'b0 : (bus.reg_rd | bus.reg_wr);
    always @(negedge clk) if (irq[0]) irq_cnt++;

    function automatic logic [1:0] gray(input int s);
        case (s & 3)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [7:0] ra(input int ch, input quad_offset_t off);
        return 8'(ch * QUAD_REGS_PER_CH + int'(off));
    endfunction

    // Channel 1 steps forward every 4 clocks while run1 is set.
    always begin
        repeat (4) @(negedge clk);
        if (run1) begin
            st1 = (st1 + 1) & 3;
            {a1, b1} = gray(st1);
        end
    end

    always @(negedge clk) begin
        if (bus.reg_ack || strobe_q) begin
            total++;
            if (bus.reg_ack !== strobe_q) begin
                bad++;
                $display("FAIL ack_timing: ack=%0b required=%0b", bus.reg_ack, strobe_q);
            end
        end
        if (bus.reg_ack) begin
            total++;
            if (sb_exp.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack: rdata=%h", bus.reg_rdata);
            end else begin
                m_exp  = sb_exp.pop_front();
                m_name = sb_name.pop_front();
                if (bus.reg_rdata !== m_exp) begin
                    bad++;
                    $display("FAIL %s: got=%h want=%h", m_name, bus.reg_rdata, m_exp);
                end
            end
        end else if (bus.reg_rdata !== 32'd0) begin
            total++;
            bad++;
            $display("FAIL rdata_idle: got=%h want=00000000", bus.reg_rdata);
        end
        while (dc_act.size() > 0) begin
            m_name = dc_name.pop_front();
            m_act  = dc_act.pop_front();
            m_exp  = dc_exp.pop_front();
            total++;
            if (m_act !== m_exp) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", m_name, m_act, m_exp);
            end
        end
    end

    task automatic dcheck(input string n, input logic [31:0] act, input logic [31:0] exp);
        dc_name.push_back(n);
        dc_act.push_back(act);
        dc_exp.push_back(exp);
    endtask

    task automatic strobe(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input string n);
        @(negedge clk);
        bus.reg_rd    = rd;
        bus.reg_wr    = wr;
        bus.reg_addr  = addr;
        bus.reg_wdata = wdata;
        sb_exp.push_back(exp);
        sb_name.push_back(n);
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus.reg_rd = 1'b0;
        bus.reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string n);
        strobe(1'b1, 1'b0, addr, 32'd0, exp, n);
        bus_idle();
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        strobe(1'b0, 1'b1, addr, data, 32'd0, "wr_ack");
        bus_idle();
    endtask

    task automatic step0(input int dir, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            st0 = (st0 + dir) & 3;
            {a0, b0} = gray(st0);
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic wait_phase(input int p);
        do @(negedge clk); while (phase != p);
    endtask

    initial begin
        bus.reg_addr  = '0;
        bus.reg_rd    = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.reg_wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        dcheck("ack_idle", 32'(bus.reg_ack), 32'd0);
        rd(ra(0, QPOS), 32'd0, "rst_pos0");
        rd(ra(0, QIDX), 32'd0, "rst_idx0");
        rd(ra(0, QVEL), 32'd0, "rst_vel0");
        rd(ra(0, QCTRL), 32'd0, "rst_ctrl0");
        rd(ra(1, QPOS), 32'd0, "rst_pos1");
        rd(ra(1, QCTRL), 32'd0, "rst_ctrl1");

        wr(ra(0, QCTRL), 32'h1);
        step0(1, 40);
        rd(ra(0, QPOS), 32'd40, "fwd_40");
        step0(-1, 40);
        rd(ra(0, QPOS), 32'd0, "rev_0");
        wr(ra(0, QCTRL), 32'h5);
        step0(1, 4);
        rd(ra(0, QPOS), 32'hFFFF_FFFC, "invert_m4");
        rd(ra(0, QCTRL), 32'h5, "ctrl_inv");

        wr(ra(0, QCTRL), 32'h1);
        @(negedge clk);
        a0 = 1'b1;
        repeat (FD - 1) @(negedge clk);
        a0 = 1'b0;
        repeat (10) @(negedge clk);
        rd(ra(0, QPOS), 32'hFFFF_FFFC, "glitch_hold");
        {a0, b0} = 2'b11;
        st0 = 2;
        repeat (10) @(negedge clk);
        rd(ra(0, QPOS), 32'hFFFF_FFFC, "illegal_hold");
        rd(ra(0, QCTRL), 32'h201, "error_set");
        wr(ra(0, QCTRL), 32'h201);
        rd(ra(0, QCTRL), 32'h001, "error_w1c");

        wr(ra(0, QPOS), 32'hFFFF_FFFF);
        rd(ra(0, QPOS), 32'hFFFF_FFFF, "pos_load");
        step0(1, 1);
        rd(ra(0, QPOS), 32'd0, "pos_wrap");
        wr(ra(0, QCTRL), 32'hB);
        wr(ra(0, QPOS), 32'd123);
        irq_base = irq_cnt;
        @(negedge clk);
        i0 = 1'b1;
        repeat (12) @(negedge clk);
        rd(ra(0, QIDX), 32'd123, "index_pos");
        rd(ra(0, QPOS), 32'd0, "index_zero");
        rd(ra(0, QCTRL), 32'h10B, "index_seen");
        dcheck("irq_pulse_cycles", 32'(irq_cnt - irq_base), 32'd1);
        i0 = 1'b0;
        repeat (8) @(negedge clk);
        wr(ra(0, QCTRL), 32'h10B);
        rd(ra(0, QCTRL), 32'h00B, "seen_w1c");

        wr(ra(1, QCTRL), 32'h1);
        run1 = 1'b1;
        repeat (600) @(negedge clk);
        rd(ra(1, QVEL), 32'd25, "vel_25");
        run1 = 1'b0;
        wr(ra(1, QCTRL), 32'h0);
        repeat (250) @(negedge clk);
        rd(ra(1, QVEL), 32'd0, "vel_disabled");

        wait_phase(10);
        wr(ra(0, QPOS), 32'd40000);
        wait_phase(10);
        rd(ra(0, QVEL), 32'h0000_7FFF, "vel_sat_pos");
        wr(ra(0, QPOS), 32'd0);
        wait_phase(10);
        rd(ra(0, QVEL), 32'hFFFF_8000, "vel_sat_neg");

        rd(8'h0C, 32'd0, "unmapped_rd");
        wr(8'h08, 32'd55);
        rd(ra(0, QPOS), 32'd0, "unmapped_wr");
        strobe(1'b1, 1'b1, ra(0, QPOS), 32'd77, 32'd0, "rdwr_ack");
        bus_idle();
        rd(ra(0, QPOS), 32'd77, "rdwr_applied");
        strobe(1'b1, 1'b0, ra(0, QCTRL), 32'd0, 32'hB, "b2b_ctrl");
        strobe(1'b1, 1'b0, ra(0, QPOS), 32'd0, 32'd77, "b2b_pos");
        bus_idle();

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd(ra(0, QPOS), 32'd0, "rerst_pos");
        rd(ra(0, QCTRL), 32'd0, "rerst_ctrl");

        repeat (5) @(negedge clk);
        dcheck("sb_empty", 32'(sb_exp.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
